// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART core.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  function automatic int bit_cycles(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_if.sv
// Host byte-stream port: push/pop strobes with Full/Empty flags.
interface uart_if;
  logic       rd_uart_en;
  logic [7:0] RX_data;
  logic       Empty;
  logic [7:0] TX_data;
  logic       wr_uart_en;
  logic       Full;

  modport slave  (input  rd_uart_en, TX_data, wr_uart_en,
                  output RX_data, Empty, Full);
  modport master (output rd_uart_en, TX_data, wr_uart_en,
                  input  RX_data, Empty, Full);
endinterface

// File: rtl/uart_fifo.sv
// Synchronous first-word fall-through FIFO; dout holds the last popped word while empty.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Extra pointer MSB separates the full case from the empty case.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push on full still lands.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? hold_q : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    hold_d   = hold_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      hold_d   = mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      hold_q   <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_core.sv
// Full-duplex 8N1 UART: RX/TX bit engines with a byte FIFO on each direction.
module uart_core
  import uart_pkg::*;
#(
  parameter int C_BAUDRATE    = 115_200,
  parameter int C_SYSTEM_FREQ = 50_000_000,
  parameter int C_FIFO_DEPTH  = 16
) (
  input  logic Clk,
  input  logic Resetn,
  input  logic RX,
  output logic TX,
  uart_if.slave host
);

  localparam int BIT_CYCLES = bit_cycles(C_SYSTEM_FREQ, C_BAUDRATE);
  localparam int HALF_BIT   = BIT_CYCLES / 2;
  localparam int CW         = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  // ---------------- RX path ----------------
  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t            rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_push;
  logic                 rx_empty, rx_full_unused;
  logic [7:0]           rx_dout;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CW'(1);
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_ferr_d  = rx_ferr_q;
    rx_push    = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == HALF_LAST) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
        rx_bit_d   = rx_bit_q + 3'd1;
        if (rx_bit_q == LAST_BIT) rx_state_d = RX_STOP;
      end
      RX_STOP: begin
        // After a framing error, park here until the line returns high.
        if (rx_ferr_q) begin
          rx_cnt_d = '0;
          if (rx_sync_q) begin
            rx_ferr_d  = 1'b0;
            rx_state_d = RX_IDLE;
          end
        end else if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          if (rx_sync_q) begin
            rx_push    = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_ferr_d = 1'b1;
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_meta_q  <= RX;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  uart_fifo #(.WIDTH(8), .DEPTH(C_FIFO_DEPTH)) u_rx_fifo (
    .clk   (Clk),
    .rst_n (Resetn),
    .push  (rx_push),
    .pop   (host.rd_uart_en),
    .din   (rx_shift_q),
    .dout  (rx_dout),
    .empty (rx_empty),
    .full  (rx_full_unused)
  );

  assign host.RX_data = rx_dout;
  assign host.Empty   = rx_empty;

  // ---------------- TX path ----------------
  tx_state_t            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_q, tx_d;
  logic                 tx_pop;
  logic                 tx_empty, tx_full;
  logic [7:0]           tx_dout;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CW'(1);
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_pop     = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_dout;
          tx_d       = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_d       = tx_shift_q[0];
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d = '0;
        tx_bit_d = tx_bit_q + 3'd1;
        if (tx_bit_q == LAST_BIT) begin
          tx_d       = 1'b1;
          tx_state_d = TX_STOP;
        end else begin
          tx_shift_d = tx_shift_q >> 1;
          tx_d       = tx_shift_q[1];
        end
      end
      TX_STOP: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d = '0;
        // Pending data chains straight into the next start bit.
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_dout;
          tx_d       = 1'b0;
          tx_state_d = TX_START;
        end else begin
          tx_d       = 1'b1;
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  uart_fifo #(.WIDTH(8), .DEPTH(C_FIFO_DEPTH)) u_tx_fifo (
    .clk   (Clk),
    .rst_n (Resetn),
    .push  (host.wr_uart_en),
    .pop   (tx_pop),
    .din   (host.TX_data),
    .dout  (tx_dout),
    .empty (tx_empty),
    .full  (tx_full)
  );

  assign host.Full = tx_full;
  assign TX        = tx_q;

endmodule

// File: tb/tb_uart_core.sv
// Scoreboard bench for uart_core: serial TX decoded by a background monitor, RX bytes via host reads.
module tb_uart_core;

  localparam int BC = 434;

  logic Clk = 1'b0;
  logic Resetn = 1'b0;
  logic RX = 1'b1;
  logic TX;

  uart_if host();

  uart_core #(
    .C_BAUDRATE    (115_200),
    .C_SYSTEM_FREQ (50_000_000),
    .C_FIFO_DEPTH  (16)
  ) dut (
    .Clk    (Clk),
    .Resetn (Resetn),
    .RX     (RX),
    .TX     (TX),
    .host   (host)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  bit mon_en = 1'b0;
  bit mon_busy = 1'b0;

  // Decode frames starting at the first cycle of a start bit; chained frames must follow with no gap.
  task automatic mon_frames();
    logic [7:0] exp;
    logic [9:0] pat;
    bit more;
    more = 1'b1;
    while (more) begin
      if (txq.size() == 0) begin
        checks++; errors++;
        $display("FAIL tx_unexpected_frame: frame seen, no byte queued");
        exp = 8'h00;
      end else begin
        exp = txq.pop_front();
      end
      pat = {1'b1, exp, 1'b0};
      for (int k = 0; k < 10; k++) begin
        checks++;
        if (TX !== pat[k]) begin
          errors++;
          $display("FAIL tx_bit_first byte=%h bit=%0d got=%b want=%b", exp, k, TX, pat[k]);
        end
        repeat (BC - 1) @(negedge Clk);
        checks++;
        if (TX !== pat[k]) begin
          errors++;
          $display("FAIL tx_bit_last byte=%h bit=%0d got=%b want=%b", exp, k, TX, pat[k]);
        end
        @(negedge Clk);
      end
      more = 1'b0;
      if (txq.size() != 0) begin
        checks++;
        if (TX !== 1'b0) begin
          errors++;
          $display("FAIL tx_gap after byte=%h got=%b want=0", exp, TX);
        end else begin
          more = 1'b1;
        end
      end
    end
  endtask

  initial forever begin
    @(negedge Clk);
    if (mon_en && Resetn && TX === 1'b0) begin
      mon_busy = 1'b1;
      mon_frames();
      mon_busy = 1'b0;
    end
  end

  task automatic drive_write(input logic [7:0] d, input bit accept);
    host.TX_data = d;
    host.wr_uart_en = 1'b1;
    if (accept) txq.push_back(d);
    @(negedge Clk);
    host.wr_uart_en = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop_bit);
    logic [9:0] pat;
    pat = {stop_bit, d, 1'b0};
    for (int k = 0; k < 10; k++) begin
      RX = pat[k];
      repeat (BC) @(negedge Clk);
    end
    RX = 1'b1;
  endtask

  task automatic read_pulse();
    host.rd_uart_en = 1'b1;
    @(negedge Clk);
    host.rd_uart_en = 1'b0;
  endtask

  task automatic wait_tx_drain();
    int n;
    n = 0;
    while ((txq.size() != 0 || mon_busy) && n < 80000) begin
      @(negedge Clk);
      n++;
    end
    checks++;
    if (txq.size() != 0 || mon_busy) begin
      errors++;
      $display("FAIL tx_drain_timeout pending=%0d busy=%0b want pending=0 busy=0", txq.size(), mon_busy);
    end
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    RX = 1'b1;
    host.rd_uart_en = 1'b0;
    host.wr_uart_en = 1'b0;
    host.TX_data = 8'h00;
    repeat (3) @(negedge Clk);
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b want=1", TX); end
    checks++; if (host.Empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b want=1", host.Empty); end
    checks++; if (host.Full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b want=0", host.Full); end
    checks++; if (host.RX_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got=%h want=00", host.RX_data); end
    Resetn = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_reset_mid_tx();
    mon_en = 1'b0;
    drive_write(8'h99, 1'b0);
    // 1499 cycles into the frame lands in data bit 2 of 0x99, which is 0.
    repeat (1500) @(negedge Clk);
    checks++; if (TX !== 1'b0) begin errors++; $display("FAIL midtx_pre_reset_tx got=%b want=0", TX); end
    #3 Resetn = 1'b0;
    #1;
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL midtx_async_tx got=%b want=1", TX); end
    checks++; if (host.Full !== 1'b0) begin errors++; $display("FAIL midtx_full got=%b want=0", host.Full); end
    checks++; if (host.Empty !== 1'b1) begin errors++; $display("FAIL midtx_empty got=%b want=1", host.Empty); end
    repeat (2) @(negedge Clk);
    Resetn = 1'b1;
    @(negedge Clk);
    mon_en = 1'b1;
  endtask

  task automatic test_tx_rx_byte();
    logic [7:0] exp;
    drive_write(8'h55, 1'b1);
    rxq.push_back(8'hAA);
    send_rx(8'hAA, 1'b1);
    repeat (5) @(negedge Clk);
    checks++; if (host.Empty !== 1'b0) begin errors++; $display("FAIL rx_byte_empty got=%b want=0", host.Empty); end
    exp = rxq.pop_front();
    checks++; if (host.RX_data !== exp) begin errors++; $display("FAIL rx_byte_data got=%h want=%h", host.RX_data, exp); end
    read_pulse();
    checks++; if (host.Empty !== 1'b1) begin errors++; $display("FAIL rx_byte_pop_empty got=%b want=1", host.Empty); end
    checks++; if (host.RX_data !== 8'hAA) begin errors++; $display("FAIL rx_byte_hold got=%h want=aa", host.RX_data); end
    wait_tx_drain();
    repeat (20) @(negedge Clk);
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL tx_idle_high got=%b want=1", TX); end
  endtask

  task automatic test_back_to_back();
    drive_write(8'hA5, 1'b1);
    repeat (3) @(negedge Clk);
    checks++; if (host.Full !== 1'b0) begin errors++; $display("FAIL b2b_not_full got=%b want=0", host.Full); end
    for (int i = 0; i < 16; i++) drive_write(8'(i), 1'b1);
    checks++; if (host.Full !== 1'b1) begin errors++; $display("FAIL b2b_full got=%b want=1", host.Full); end
    drive_write(8'hFF, 1'b0);
    checks++; if (host.Full !== 1'b1) begin errors++; $display("FAIL b2b_full_after_drop got=%b want=1", host.Full); end
  endtask

  task automatic test_rx_errors();
    RX = 1'b0;
    repeat (100) @(negedge Clk);
    RX = 1'b1;
    repeat (600) @(negedge Clk);
    checks++; if (host.Empty !== 1'b1) begin errors++; $display("FAIL glitch_empty got=%b want=1", host.Empty); end
    send_rx(8'h3C, 1'b0);
    repeat (20) @(negedge Clk);
    checks++; if (host.Empty !== 1'b1) begin errors++; $display("FAIL framing_empty got=%b want=1", host.Empty); end
    checks++; if (host.RX_data !== 8'hAA) begin errors++; $display("FAIL framing_hold got=%h want=aa", host.RX_data); end
    read_pulse();
    checks++; if (host.Empty !== 1'b1) begin errors++; $display("FAIL underflow_empty got=%b want=1", host.Empty); end
    checks++; if (host.RX_data !== 8'hAA) begin errors++; $display("FAIL underflow_hold got=%h want=aa", host.RX_data); end
  endtask

  task automatic test_rx_overflow();
    logic [7:0] exp;
    for (int i = 1; i <= 17; i++) begin
      if (i <= 16) rxq.push_back(8'(i));
      send_rx(8'(i), 1'b1);
    end
    repeat (5) @(negedge Clk);
    for (int i = 0; i < 16; i++) begin
      checks++; if (host.Empty !== 1'b0) begin errors++; $display("FAIL ovf_empty read=%0d got=%b want=0", i, host.Empty); end
      exp = rxq.pop_front();
      checks++; if (host.RX_data !== exp) begin errors++; $display("FAIL ovf_data read=%0d got=%h want=%h", i, host.RX_data, exp); end
      read_pulse();
    end
    checks++; if (host.Empty !== 1'b1) begin errors++; $display("FAIL ovf_drained_empty got=%b want=1", host.Empty); end
    checks++; if (host.RX_data !== 8'h10) begin errors++; $display("FAIL ovf_hold got=%h want=10", host.RX_data); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_tx();
    test_tx_rx_byte();
    test_back_to_back();
    test_rx_errors();
    test_rx_overflow();
    wait_tx_drain();
    repeat (5) @(negedge Clk);
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL final_tx_idle got=%b want=1", TX); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
